// File: rtl/shift_reg_load_ctrl_pkg.sv
// Shared types and sizes for the serial shift-register load sequencer.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

endpackage

// File: rtl/shift_reg_load_ctrl_if.sv
// Requester-side bus of the load sequencer: request/word/direction in, grant/status out.
interface shift_reg_load_ctrl_if #(parameter int MSB = 16);
    import shift_ctrl_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [MSB-1:0]     req_data0;
    logic [MSB-1:0]     req_data1;
    logic [NUM_REQ-1:0] req_dir;
    logic               abort;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;
    logic               done;
    logic [ID_W-1:0]    done_id;

    modport master (
        output req, req_data0, req_data1, req_dir, abort,
        input  gnt, busy, done, done_id
    );

    modport slave (
        input  req, req_data0, req_data1, req_dir, abort,
        output gnt, busy, done, done_id
    );

endinterface

// File: rtl/shift_reg_load_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; 'last' remembers the most recently granted requester.
module rr_arb2
    import shift_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    last
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last[0] ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last <= ID_W'(1);
        end else if (advance && |gnt) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/shift_reg_load_ctrl.sv
// Grants one requester at a time and streams its word into an external MSB-bit
// serial shift register, then reports which requester was served.
module shift_reg_load_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int MSB = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    shift_reg_load_ctrl_if.slave  bus,
    output logic                  sr_d,
    output logic                  sr_en,
    output logic                  sr_dir
);

    localparam int CNT_W = (MSB > 1) ? $clog2(MSB) : 1;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [MSB-1:0]      word_q;
    logic                dir_q;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]     arb_last;
    logic                grant;
    logic                cancel;

    function automatic logic pick_bit(input logic [MSB-1:0] w,
                                      input logic [CNT_W-1:0] c,
                                      input logic dir);
        logic [CNT_W-1:0] idx;
        idx = dir ? c : CNT_W'(MSB - 1) - c;
        return w[idx];
    endfunction

    assign grant = (state == IDLE) && (|bus.req);
    // Abort only bites while a shift is actually being presented to the register.
    assign cancel = bus.abort && sr_en;

    rr_arb2 u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (bus.req),
        .advance (grant),
        .gnt     (arb_gnt),
        .last    (arb_last)
    );

    always_ff @(posedge clk) begin
        if (grant) begin
            word_q <= arb_gnt[1] ? bus.req_data1 : bus.req_data0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            dir_q       <= 1'b0;
            bus.gnt     <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.done_id <= '0;
            sr_d        <= 1'b0;
            sr_en       <= 1'b0;
            sr_dir      <= 1'b0;
        end else begin
            bus.gnt  <= '0;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    sr_en <= 1'b0;
                    sr_d  <= 1'b0;
                    cnt   <= '0;
                    if (grant) begin
                        bus.gnt  <= arb_gnt;
                        bus.busy <= 1'b1;
                        dir_q    <= bus.req_dir[arb_gnt[1]];
                        state    <= SHIFT;
                    end else begin
                        bus.busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cancel) begin
                        sr_en    <= 1'b0;
                        sr_d     <= 1'b0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        sr_en  <= 1'b1;
                        sr_dir <= dir_q;
                        sr_d   <= pick_bit(word_q, cnt, dir_q);
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_W'(MSB - 1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // The final shift is on the wire this cycle; an abort here still cancels.
                    sr_en <= 1'b0;
                    sr_d  <= 1'b0;
                    state <= IDLE;
                    if (cancel) begin
                        bus.busy <= 1'b0;
                    end else begin
                        bus.done    <= 1'b1;
                        bus.done_id <= arb_last;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
